// File: rtl/i2c_codec_cfg_slave.sv
// I2C write-only target for 3-byte codec configuration transfers.
// Filters SCL/SDA, ACKs DEV_ADDR+W and strobes out 7-bit address / 9-bit data.
module i2c_codec_cfg_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         FILT_LEN = 3
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       oWR_STB,
    output logic [6:0] oREG_ADDR,
    output logic [8:0] oREG_DATA,
    output logic       oBUSY,
    output logic       oERR
);

    localparam int CW = $clog2(FILT_LEN + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, EXTRA, IGNORE
    } stateT;

    stateT state, stateNxt;

    logic [1:0]    sclSync, sdaSync;
    logic          sclF, sdaF;
    logic [CW-1:0] sclCnt, sdaCnt;
    logic          sclUpd, sdaUpd;
    logic          sclRise, sclFall;
    logic          startDet, stopDet, frame;

    logic [2:0] bitCnt;
    logic [6:0] shReg;
    logic [7:0] byte1;
    logic [7:0] byteIn;
    logic       byteDone;
    logic       shiftEn;
    logic       skip;
    logic       sdaOe;
    logic       stbNxt, errNxt, oeNxt;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sclSync <= 2'b11;
            sdaSync <= 2'b11;
        end else begin
            sclSync <= {sclSync[0], I2C_SCLK};
            sdaSync <= {sdaSync[0], I2C_SDAT};
        end
    end

    // A new level is accepted once it has differed for FILT_LEN cycles in a row
    assign sclUpd = (sclSync[1] != sclF) && (sclCnt == CW'(FILT_LEN - 1));
    assign sdaUpd = (sdaSync[1] != sdaF) && (sdaCnt == CW'(FILT_LEN - 1));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sclF   <= 1'b1;
            sdaF   <= 1'b1;
            sclCnt <= '0;
            sdaCnt <= '0;
        end else begin
            if (sclSync[1] == sclF || sclUpd) sclCnt <= '0;
            else                              sclCnt <= sclCnt + CW'(1);
            if (sdaSync[1] == sdaF || sdaUpd) sdaCnt <= '0;
            else                              sdaCnt <= sdaCnt + CW'(1);
            if (sclUpd) sclF <= sclSync[1];
            if (sdaUpd) sdaF <= sdaSync[1];
        end
    end

    assign sclRise  = sclUpd & sclSync[1];
    assign sclFall  = sclUpd & ~sclSync[1];
    // an SCL edge in the same cycle wins; no START/STOP then
    assign startDet = sdaUpd & ~sdaSync[1] & sclF & ~sclUpd;
    assign stopDet  = sdaUpd & sdaSync[1] & sclF & ~sclUpd;
    assign frame    = startDet | stopDet;

    assign byteIn   = {shReg, sdaF};
    assign byteDone = sclRise && (bitCnt == 3'd7);
    assign shiftEn  = sclRise && ((state == ADDR) || (state == BYTE1) ||
                                  (state == BYTE2) ||
                                  ((state == EXTRA) && !skip));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= IDLE;
        else         state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        if (startDet) begin
            stateNxt = ADDR;
        end else if (stopDet) begin
            stateNxt = IDLE;
        end else begin
            case (state)
                ADDR:
                    if (byteDone)
                        stateNxt = (byteIn == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
                ACK_A: if (sclFall && sdaOe) stateNxt = BYTE1;
                BYTE1: if (byteDone) stateNxt = ACK_1;
                ACK_1: if (sclFall && sdaOe) stateNxt = BYTE2;
                BYTE2: if (byteDone) stateNxt = ACK_2;
                ACK_2: if (sclFall && sdaOe) stateNxt = EXTRA;
                default: ;
            endcase
        end
    end

    always_comb begin
        stbNxt = 1'b0;
        errNxt = 1'b0;
        oeNxt  = 1'b0;
        if (frame) begin
            errNxt = (state == BYTE1) || (state == ACK_1) || (state == BYTE2) ||
                     ((state == ADDR) && (bitCnt != 3'd0));
        end else begin
            stbNxt = (state == BYTE2) && byteDone;
            errNxt = (state == EXTRA) && byteDone && !skip;
            // ACK drive starts on the first SCL fall, ends on the second
            if ((state == ACK_A) || (state == ACK_1) || (state == ACK_2))
                oeNxt = sdaOe ^ sclFall;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bitCnt    <= 3'd0;
            shReg     <= 7'd0;
            byte1     <= 8'd0;
            skip      <= 1'b0;
            sdaOe     <= 1'b0;
            oWR_STB   <= 1'b0;
            oERR      <= 1'b0;
            oBUSY     <= 1'b0;
            oREG_ADDR <= 7'd0;
            oREG_DATA <= 9'd0;
        end else begin
            oWR_STB <= stbNxt;
            oERR    <= errNxt;
            sdaOe   <= oeNxt;
            if (startDet)     oBUSY <= 1'b1;
            else if (stopDet) oBUSY <= 1'b0;
            if (frame) begin
                bitCnt <= 3'd0;
                skip   <= 1'b0;
            end else if (shiftEn) begin
                shReg  <= byteIn[6:0];
                bitCnt <= bitCnt + 3'd1;
                if ((state == EXTRA) && byteDone) skip <= 1'b1;
            end else if (sclRise && (state == EXTRA) && skip) begin
                skip <= 1'b0;
            end
            if (!frame && (state == BYTE1) && byteDone) byte1 <= byteIn;
            if (stbNxt) begin
                oREG_ADDR <= byte1[7:1];
                oREG_DATA <= {byte1[0], byteIn};
            end
        end
    end

    assign I2C_SDAT = (sdaOe && !frame) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_codec_cfg_slave.sv
// Bench for i2c_codec_cfg_slave: bit-banged I2C initiator plus
// a byte-level model of expected ACKs, strobes and error pulses.
module tb_i2c_codec_cfg_slave;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       scl = 1'b1;
    logic       sdaLow = 1'b0;
    wire        sdaBus;
    logic       oWR_STB, oBUSY, oERR;
    logic [6:0] oREG_ADDR;
    logic [8:0] oREG_DATA;

    int total = 0;
    int bad = 0;
    int q = 10;
    int errCnt = 0;
    int expErr = 0;
    int dutLow = 0;
    logic [15:0] gotQ[$];
    logic [15:0] expQ[$];

    pullup (sdaBus);
    assign sdaBus = sdaLow ? 1'b0 : 1'bz;

    always #10 iCLK = ~iCLK;

    i2c_codec_cfg_slave dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .I2C_SCLK (scl),
        .I2C_SDAT (sdaBus),
        .oWR_STB  (oWR_STB),
        .oREG_ADDR(oREG_ADDR),
        .oREG_DATA(oREG_DATA),
        .oBUSY    (oBUSY),
        .oERR     (oERR)
    );

    always @(negedge iCLK) begin
        if (oWR_STB) gotQ.push_back({oREG_ADDR, oREG_DATA});
        if (oERR) errCnt++;
        if (!sdaLow && sdaBus === 1'b0) dutLow++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitc(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic mStart;
        sdaLow = 1'b0; waitc(q);
        scl = 1'b1;    waitc(q);
        sdaLow = 1'b1; waitc(q);
        scl = 1'b0;    waitc(q);
    endtask

    task automatic mStop;
        sdaLow = 1'b1; waitc(q);
        scl = 1'b1;    waitc(q);
        sdaLow = 1'b0; waitc(q);
    endtask

    // gl: 1 = one-cycle SCL glitch mid-byte, 2 = reset during ACK clock
    task automatic wb(input logic [7:0] b, input int gl, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sdaLow = ~b[i]; waitc(q);
            scl = 1'b1;     waitc(2 * q);
            scl = 1'b0;     waitc(q);
            if (gl == 1 && i == 4) begin
                scl = 1'b1;
                @(posedge iCLK); #1;
                scl = 1'b0;
                waitc(q);
            end
        end
        sdaLow = 1'b0; waitc(q);
        scl = 1'b1;    waitc(q);
        ack = (sdaBus === 1'b0);
        if (gl == 2) begin
            chk("rst-drv", sdaBus, 0);
            iRST_N = 1'b0;
            #1;
            chk("rst-rel", sdaBus, 1);
            chk("rst-out", {oWR_STB, oERR, oBUSY, oREG_ADDR, oREG_DATA}, 0);
        end
        waitc(q);
        scl = 1'b0; waitc(q);
        if (gl == 2) begin
            iRST_N = 1'b1;
            waitc(q);
        end
    endtask

    task automatic xfer(input logic [7:0] b0, b1, b2, b3,
                        input int n, input int gl);
        logic       ack;
        logic       match;
        logic [7:0] bv;
        logic [6:0] ea;
        logic [8:0] ed;
        match = (b0 == 8'h34);
        mStart;
        chk("busy", oBUSY, 1);
        for (int i = 0; i < n; i++) begin
            bv = (i == 0) ? b0 : (i == 1) ? b1 : (i == 2) ? b2 : b3;
            wb(bv, ((i == 1 && gl == 1) || (i == 2 && gl == 2)) ? gl : 0, ack);
            chk($sformatf("ack%0d", i), ack, (match && i < 3) ? 1 : 0);
            if (!match) break;
        end
        if (match) begin
            if (n >= 3) begin
                ea = b1[7:1];
                ed = {b1[0], b2};
                expQ.push_back({ea, ed});
            end
            expErr += (n < 3) ? 1 : n - 3;
        end
    endtask

    task automatic endStop(input string tag);
        mStop;
        waitc(20);
        chk({tag, "-busy"}, oBUSY, 0);
        chk({tag, "-err"}, errCnt, expErr);
        chk({tag, "-nstb"}, gotQ.size(), expQ.size());
        while (expQ.size() > 0 && gotQ.size() > 0)
            chk({tag, "-stb"}, gotQ.pop_front(), expQ.pop_front());
        gotQ.delete();
        expQ.delete();
    endtask

    initial begin
        int lowBefore;
        int n;
        logic [7:0] r0;
        waitc(5);
        chk("rst-state", {oWR_STB, oERR, oBUSY, oREG_ADDR, oREG_DATA}, 0);
        chk("rst-sda", sdaBus, 1);
        iRST_N = 1'b1;
        waitc(20);

        q = 125;
        xfer(8'h34, 8'h00, 8'h1A, 8'h00, 3, 0);
        endStop("t1");
        q = 10;

        xfer(8'h34, 8'h12, 8'h01, 8'h00, 3, 0);
        xfer(8'h34, 8'h0E, 8'h01, 8'h00, 3, 0);
        endStop("t2");

        lowBefore = dutLow;
        xfer(8'h40, 8'h00, 8'h00, 8'h00, 1, 0);
        endStop("t3a");
        xfer(8'h35, 8'h00, 8'h00, 8'h00, 1, 0);
        endStop("t3b");
        chk("t3-nodrive", dutLow - lowBefore, 0);
        xfer(8'h34, 8'h08, 8'hF8, 8'h00, 3, 0);
        endStop("t3c");

        xfer(8'h34, 8'h0A, 8'h00, 8'h00, 2, 0);
        xfer(8'h34, 8'h0C, 8'h00, 8'h00, 3, 0);
        endStop("t4");

        xfer(8'h34, 8'h10, 8'h02, 8'h55, 4, 0);
        endStop("t5");

        xfer(8'h34, 8'h22, 8'h5A, 8'h00, 3, 1);
        endStop("t6g");
        xfer(8'h34, 8'h44, 8'h66, 8'h00, 3, 2);
        endStop("t6r");
        xfer(8'h34, 8'h02, 8'h03, 8'h00, 3, 0);
        endStop("t6n");

        for (int k = 0; k < 8; k++) begin
            n  = $urandom_range(1, 4);
            r0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34;
            xfer(r0, 8'($urandom), 8'($urandom), 8'($urandom), n, 0);
            if ($urandom_range(0, 1) == 1 || k == 7) endStop("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
